// File: rtl/line_buffer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : line_buffer_pkg                                         |
// | Brief    : Shared types and constants for the 3-line video buffer. |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package line_buffer_pkg;

    localparam int HRES_DEFAULT = 1280;
    localparam int VRES_DEFAULT = 720;
    localparam int LB_LATENCY   = 2;
    localparam int LB_ROWS      = 3;

    typedef logic [15:0] pixel_t;

    function automatic logic [1:0] sel_next(input logic [1:0] sel);
        return (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    endfunction

endpackage : line_buffer_pkg
`default_nettype wire

// File: rtl/line_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : line_buffer_if                                          |
// | Brief    : Pixel-in / pixel-column-out bundle of the line buffer.  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface line_buffer_if;
    import line_buffer_pkg::*;

    logic [10:0]      hcount_in;
    logic [9:0]       vcount_in;
    pixel_t           pixel_data_in;
    logic             data_valid_in;
    pixel_t [2:0]     line_buffer_out;
    logic [10:0]      hcount_out;
    logic [9:0]       vcount_out;
    logic             data_valid_out;

    modport master (
        output hcount_in, vcount_in, pixel_data_in, data_valid_in,
        input  line_buffer_out, hcount_out, vcount_out, data_valid_out
    );

    modport slave (
        input  hcount_in, vcount_in, pixel_data_in, data_valid_in,
        output line_buffer_out, hcount_out, vcount_out, data_valid_out
    );

endinterface : line_buffer_if
`default_nettype wire

// File: rtl/line_ram.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : line_ram                                                |
// | Brief    : Simple dual-port line RAM, registered 2-cycle read.     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module line_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1280,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_wr_en,
    input  wire logic [AW-1:0]    i_wr_addr,
    input  wire logic [WIDTH-1:0] i_wr_data,
    input  wire logic [AW-1:0]    i_rd_addr,
    output logic      [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_stage;
    logic [WIDTH-1:0] r_rd_data;

    // Array and first read stage carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_stage <= r_mem[i_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_rd_stage;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : line_ram
`default_nettype wire

// File: rtl/line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : line_buffer                                             |
// | Brief    : Three rotating line RAMs giving a 3-pixel column.       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module line_buffer
    import line_buffer_pkg::*;
#(
    parameter int HRES = HRES_DEFAULT,
    parameter int VRES = VRES_DEFAULT
) (
    input  wire logic     clk_in,
    input  wire logic     rst_in,
    line_buffer_if.slave  lb_bus
);

    localparam int          c_AW    = (HRES > 1) ? $clog2(HRES) : 1;
    localparam logic [10:0] c_HLAST = 11'(HRES - 1);
    localparam logic [9:0]  c_VLAST = 10'(VRES - 1);

    logic [1:0]  r_wr_sel;
    logic [1:0]  r_sel_d1;
    logic [1:0]  r_sel_d2;
    pixel_t      r_pix_d1;
    pixel_t      r_pix_d2;
    logic [10:0] r_hcount_d1;
    logic [10:0] r_hcount_d2;
    logic [9:0]  r_vcount_d1;
    logic [9:0]  r_vcount_d2;
    logic        r_valid_d1;
    logic        r_valid_d2;

    logic        w_in_range;
    logic        w_line_end;
    logic [9:0]  w_vcount_prev;
    pixel_t      w_rd_data [LB_ROWS];
    pixel_t      w_row_old;
    pixel_t      w_row_mid;

    assign w_in_range    = (lb_bus.hcount_in <= c_HLAST);
    assign w_line_end    = lb_bus.data_valid_in && (lb_bus.hcount_in == c_HLAST);
    assign w_vcount_prev = (lb_bus.vcount_in == 10'd0) ? c_VLAST
                                                       : lb_bus.vcount_in - 10'd1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_sel    <= 2'd0;
            r_sel_d1    <= 2'd0;
            r_sel_d2    <= 2'd0;
            r_pix_d1    <= '0;
            r_pix_d2    <= '0;
            r_hcount_d1 <= '0;
            r_hcount_d2 <= '0;
            r_vcount_d1 <= '0;
            r_vcount_d2 <= '0;
            r_valid_d1  <= 1'b0;
            r_valid_d2  <= 1'b0;
        end else begin
            if (w_line_end) begin
                r_wr_sel <= sel_next(r_wr_sel);
            end
            // Read-side RAM choice travels with the data it selects.
            r_sel_d1    <= r_wr_sel;
            r_sel_d2    <= r_sel_d1;
            r_pix_d1    <= lb_bus.pixel_data_in;
            r_pix_d2    <= r_pix_d1;
            r_hcount_d1 <= lb_bus.hcount_in;
            r_hcount_d2 <= r_hcount_d1;
            r_vcount_d1 <= w_vcount_prev;
            r_vcount_d2 <= r_vcount_d1;
            r_valid_d1  <= lb_bus.data_valid_in;
            r_valid_d2  <= r_valid_d1;
        end
    end

    for (genvar g = 0; g < LB_ROWS; g++) begin : g_ram
        logic w_wr_en;

        assign w_wr_en = lb_bus.data_valid_in && w_in_range && (r_wr_sel == 2'(g));

        line_ram #(
            .WIDTH ($bits(pixel_t)),
            .DEPTH (HRES),
            .AW    (c_AW)
        ) u_line_ram (
            .clk       (clk_in),
            .rst       (rst_in),
            .i_wr_en   (w_wr_en),
            .i_wr_addr (lb_bus.hcount_in[c_AW-1:0]),
            .i_wr_data (lb_bus.pixel_data_in),
            .i_rd_addr (lb_bus.hcount_in[c_AW-1:0]),
            .o_rd_data (w_rd_data[g])
        );
    end

    // The RAM after the write target holds line v-2, the one after that v-1.
    always_comb begin
        w_row_old = w_rd_data[0];
        w_row_mid = w_rd_data[1];
        unique case (r_sel_d2)
            2'd0: begin
                w_row_old = w_rd_data[1];
                w_row_mid = w_rd_data[2];
            end
            2'd1: begin
                w_row_old = w_rd_data[2];
                w_row_mid = w_rd_data[0];
            end
            default: begin
                w_row_old = w_rd_data[0];
                w_row_mid = w_rd_data[1];
            end
        endcase
    end

    assign lb_bus.line_buffer_out[0] = w_row_old;
    assign lb_bus.line_buffer_out[1] = w_row_mid;
    assign lb_bus.line_buffer_out[2] = r_pix_d2;
    assign lb_bus.hcount_out         = r_hcount_d2;
    assign lb_bus.vcount_out         = r_vcount_d2;
    assign lb_bus.data_valid_out     = r_valid_d2;

endmodule : line_buffer
`default_nettype wire

// File: tb/tb_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_line_buffer                                          |
// | Brief    : Self-checking bench: line-history model plus vectors.   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_line_buffer;
    import line_buffer_pkg::*;

    localparam int HRES = 1280;
    localparam int VRES = 720;

    logic clk_in;
    logic rst_in;
    line_buffer_if bus ();

    line_buffer #(.HRES(HRES), .VRES(VRES)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .lb_bus (bus.slave)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    typedef struct {
        bit          valid;
        bit          chk_hv;
        bit          chk_r2;
        bit          k0;
        bit          k1;
        logic [10:0] h;
        logic [9:0]  v;
        logic [15:0] r0;
        logic [15:0] r1;
        logic [15:0] r2;
    } exp_t;

    typedef struct {
        int          h;
        int          v;
        logic [15:0] pix;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [10:0] eh;
        logic [9:0]  ev;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: contents of the line in progress and the two completed before it.
    logic [15:0] cur   [HRES];
    logic [15:0] prev1 [HRES];
    logic [15:0] prev2 [HRES];
    bit          kc    [HRES];
    bit          kp1   [HRES];
    bit          kp2   [HRES];
    int          lines_done = 0;
    exp_t        e_d1;
    exp_t        e_d2;

    function automatic logic [15:0] pat(input int l, input int c);
        return {5'(l), 11'(c)};
    endfunction

    function automatic exp_t blank();
        exp_t r;
        r.valid = 0; r.chk_hv = 0; r.chk_r2 = 0; r.k0 = 0; r.k1 = 0;
        r.h = '0; r.v = '0; r.r0 = '0; r.r1 = '0; r.r2 = '0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        exp_t n;
        int   h;
        n = blank();
        if (rst_in) begin
            foreach (kc[i]) begin kc[i] = 0; kp1[i] = 0; kp2[i] = 0; end
            lines_done = 0;
            n.chk_hv = 1; n.chk_r2 = 1;
            e_d1 = n;
            n.k0 = 1; n.k1 = 1;
            e_d2 = n;
        end else begin
            h       = int'(bus.hcount_in);
            n.valid = bus.data_valid_in;
            n.h     = bus.hcount_in;
            n.v     = (bus.vcount_in == 10'd0) ? 10'(VRES - 1) : bus.vcount_in - 10'd1;
            if (n.valid) begin
                n.chk_hv = 1;
                if (h < HRES) begin
                    n.chk_r2 = 1; n.r2 = bus.pixel_data_in;
                    n.k0 = kp2[h]; n.r0 = prev2[h];
                    n.k1 = kp1[h]; n.r1 = prev1[h];
                    cur[h] = bus.pixel_data_in;
                    kc[h]  = 1;
                    if (h == HRES - 1) begin
                        prev2 = prev1; kp2 = kp1;
                        prev1 = cur;   kp1 = kc;
                        foreach (kc[i]) kc[i] = 0;
                        lines_done++;
                    end
                end
            end
            e_d2 = e_d1;
            e_d1 = n;
        end
    endtask

    task automatic check_outputs();
        chk("data_valid_out", 32'(bus.data_valid_out), 32'(e_d2.valid));
        if (e_d2.chk_hv) begin
            chk("hcount_out", 32'(bus.hcount_out), 32'(e_d2.h));
            chk("vcount_out", 32'(bus.vcount_out), 32'(e_d2.v));
        end
        if (e_d2.chk_r2) chk("row2", 32'(bus.line_buffer_out[2]), 32'(e_d2.r2));
        if (e_d2.k0)     chk("row0", 32'(bus.line_buffer_out[0]), 32'(e_d2.r0));
        if (e_d2.k1)     chk("row1", 32'(bus.line_buffer_out[1]), 32'(e_d2.r1));
        chk("wr_sel", 32'(dut.r_wr_sel), 32'(lines_done % 3));
    endtask

    task automatic cycle();
        @(posedge clk_in);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive_px(input int h, input int v, input logic [15:0] pix);
        bus.data_valid_in = 1'b1;
        bus.hcount_in     = 11'(h);
        bus.vcount_in     = 10'(v);
        bus.pixel_data_in = pix;
        cycle();
    endtask

    // Idle cycles carry junk coordinates; only data_valid_in may qualify them.
    task automatic drive_idle();
        bus.data_valid_in = 1'b0;
        bus.hcount_in     = 11'($urandom);
        bus.vcount_in     = 10'($urandom_range(VRES - 1, 0));
        bus.pixel_data_in = 16'($urandom);
        cycle();
    endtask

    task automatic run_cols(input int v, input int c0, input int c1, input bit rnd, input int idle_pct);
        for (int c = c0; c <= c1; c++) begin
            if (int'($urandom_range(99, 0)) < idle_pct) drive_idle();
            drive_px(c, v, rnd ? 16'($urandom) : pat(v, c));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [4];
        logic [1:0]  sel_after [3];

        tbl[0] = '{5,    3, 16'h1805, 16'h0805, 16'h1005, 16'h1805, 11'd5,    10'd2};
        tbl[1] = '{0,    3, 16'h1800, 16'h0800, 16'h1000, 16'h1800, 11'd0,    10'd2};
        tbl[2] = '{700,  3, 16'h1ABC, 16'h0ABC, 16'h12BC, 16'h1ABC, 11'd700,  10'd2};
        tbl[3] = '{1279, 3, 16'h1CFF, 16'h0CFF, 16'h14FF, 16'h1CFF, 11'd1279, 10'd2};
        sel_after[0] = 2'd1; sel_after[1] = 2'd2; sel_after[2] = 2'd0;
        e_d1 = blank();
        e_d2 = blank();

        rst_in = 1'b1;
        bus.data_valid_in = 1'b0; bus.hcount_in = '0; bus.vcount_in = '0; bus.pixel_data_in = '0;
        cycle();
        cycle();
        rst_in = 1'b0;
        chk("reset_valid", 32'(bus.data_valid_out), 32'd0);
        chk("reset_wr_sel", 32'(dut.r_wr_sel), 32'd0);
        drive_idle();
        drive_idle();

        // Line 0 start: vcount 0 wraps to VRES-1 at the output.
        drive_px(0, 0, pat(0, 0));
        drive_px(1, 0, pat(0, 1));
        chk("wrap_valid", 32'(bus.data_valid_out), 32'd1);
        chk("wrap_vcount", 32'(bus.vcount_out), 32'd719);
        chk("wrap_hcount", 32'(bus.hcount_out), 32'd0);
        run_cols(0, 2, HRES - 1, 0, 5);
        chk("sel_line0", 32'(dut.r_wr_sel), 32'(sel_after[0]));
        for (int l = 1; l < 3; l++) begin
            run_cols(l, 0, HRES - 1, 0, 5);
            chk("sel_line_end", 32'(dut.r_wr_sel), 32'(sel_after[l]));
        end

        for (int i = 0; i < 4; i++) begin
            drive_px(tbl[i].h, tbl[i].v, tbl[i].pix);
            drive_idle();
            chk("tbl_valid",  32'(bus.data_valid_out),     32'd1);
            chk("tbl_row0",   32'(bus.line_buffer_out[0]), 32'(tbl[i].e0));
            chk("tbl_row1",   32'(bus.line_buffer_out[1]), 32'(tbl[i].e1));
            chk("tbl_row2",   32'(bus.line_buffer_out[2]), 32'(tbl[i].e2));
            chk("tbl_hcount", 32'(bus.hcount_out),         32'(tbl[i].eh));
            chk("tbl_vcount", 32'(bus.vcount_out),         32'(tbl[i].ev));
        end
        chk("sel_line3", 32'(dut.r_wr_sel), 32'd1);

        run_cols(4, 0, HRES - 1, 1, 10);
        run_cols(5, 0, HRES - 1, 1, 10);

        // Long blanking gap in the middle of line 6.
        run_cols(6, 0, 399, 1, 10);
        for (int i = 0; i < 37; i++) drive_idle();
        chk("gap_wr_sel", 32'(dut.r_wr_sel), 32'd0);
        drive_px(400, 6, 16'($urandom));
        chk("gap_resume_v0", 32'(bus.data_valid_out), 32'd0);
        drive_px(401, 6, 16'($urandom));
        chk("gap_resume_v1", 32'(bus.data_valid_out), 32'd1);
        chk("gap_resume_h",  32'(bus.hcount_out), 32'd400);
        chk("gap_resume_vc", 32'(bus.vcount_out), 32'd5);
        run_cols(6, 402, HRES - 1, 1, 10);

        // Out-of-range column is passed through but never stored.
        run_cols(7, 0, 499, 1, 10);
        drive_px(1300, 7, 16'hBEEF);
        drive_idle();
        chk("oor_valid",  32'(bus.data_valid_out), 32'd1);
        chk("oor_hcount", 32'(bus.hcount_out), 32'd1300);
        chk("oor_vcount", 32'(bus.vcount_out), 32'd6);
        chk("oor_wr_sel", 32'(dut.r_wr_sel), 32'd1);
        run_cols(7, 500, HRES - 1, 1, 10);
        run_cols(8, 0, HRES - 1, 1, 10);
        run_cols(9, 0, HRES - 1, 1, 10);

        // Reset in the middle of line 10.
        run_cols(10, 0, 599, 0, 0);
        rst_in = 1'b1;
        bus.data_valid_in = 1'b1; bus.hcount_in = 11'd600; bus.vcount_in = 10'd10;
        bus.pixel_data_in = pat(10, 600);
        cycle();
        rst_in = 1'b0;
        chk("rst_valid",  32'(bus.data_valid_out),     32'd0);
        chk("rst_hcount", 32'(bus.hcount_out),         32'd0);
        chk("rst_vcount", 32'(bus.vcount_out),         32'd0);
        chk("rst_row0",   32'(bus.line_buffer_out[0]), 32'd0);
        chk("rst_row1",   32'(bus.line_buffer_out[1]), 32'd0);
        chk("rst_row2",   32'(bus.line_buffer_out[2]), 32'd0);
        chk("rst_wr_sel", 32'(dut.r_wr_sel),           32'd0);
        drive_idle();
        chk("post_rst_v0", 32'(bus.data_valid_out), 32'd0);
        drive_idle();
        chk("post_rst_v1", 32'(bus.data_valid_out), 32'd0);
        drive_px(0, 0, pat(0, 0));
        chk("post_rst_v2", 32'(bus.data_valid_out), 32'd0);
        drive_px(1, 0, pat(0, 1));
        chk("post_rst_v3",  32'(bus.data_valid_out), 32'd1);
        chk("post_rst_vc",  32'(bus.vcount_out), 32'd719);
        run_cols(0, 2, HRES - 1, 1, 5);
        run_cols(1, 0, 300, 1, 5);
        drive_idle();
        drive_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_line_buffer
`default_nettype wire

// File: doc/line_buffer.md
LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 Parameter HRES, default 1280, active pixels per line.
REQ-002 Parameter VRES, default 720, active lines per frame.
REQ-003 Clocking SHALL be one clock, clk_in; reset SHALL be rst_in, synchronous and active-high.
REQ-004 clk_in  input  1  pixel clock.
REQ-005 rst_in  input  1  synchronous active-high reset.
REQ-006 hcount_in  input  11  column of the incoming pixel, 0..HRES-1.
REQ-007 vcount_in  input  10  line of the incoming pixel, 0..VRES-1.
REQ-008 pixel_data_in  input  16  RGB565 pixel.
REQ-009 data_valid_in  input  1  qualifies pixel_data_in, hcount_in and vcount_in.
REQ-010 line_buffer_out  output  3x16  vertical column of pixels, index 0 = oldest line.
REQ-011 hcount_out  output  11  column of line_buffer_out.
REQ-012 vcount_out  output  10  centre line of line_buffer_out.
REQ-013 data_valid_out  output  1  qualifies all outputs; feeds the 3x3 convolution stage directly.

Function
REQ-014 Storage SHALL be 3 line RAMs, each HRES x 16 bits, addressed by hcount.
REQ-015 Register wr_sel (0..2) SHALL select the RAM that receives the current line.
REQ-016 On data_valid_in, the block SHALL write pixel_data_in to RAM[wr_sel] at address hcount_in.
REQ-017 In the same cycle, the block SHALL read RAM[(wr_sel+1) mod 3] (line v-2) and RAM[(wr_sel+2) mod 3] (line v-1) at hcount_in.
REQ-018 Latency SHALL be exactly 2 cycles input to output: 2-cycle RAM read, with the incoming pixel delayed 2 registers alongside it.
REQ-019 line_buffer_out[0] SHALL be line v-2, [1] line v-1, [2] line v (bypassed incoming pixel), all at the same column.
REQ-020 The read-RAM selection SHALL be captured at request time and pipelined with the data, so a wr_sel change does not corrupt in-flight reads.
REQ-021 hcount_out SHALL be hcount_in delayed 2 cycles.
REQ-022 vcount_out SHALL be vcount_in-1 delayed 2 cycles; vcount_in=0 SHALL give VRES-1 (wrap).
REQ-023 data_valid_out SHALL be data_valid_in delayed 2 cycles.
REQ-024 wr_sel SHALL advance mod 3 (2 -> 0) after the write of the cycle where data_valid_in=1 and hcount_in=HRES-1.
REQ-025 wr_sel SHALL NOT advance on cycles with data_valid_in=0, including any blanking length.
REQ-026 Writes and reads in one cycle always target different RAMs; no read-during-write hazard exists.
REQ-027 Content of rows 0/1 for the first two lines after reset is unspecified; data_valid_out SHALL still follow data_valid_in.
REQ-028 hcount_in >= HRES with data_valid_in=1 SHALL be ignored: no write, no wr_sel change; data_valid_out is still asserted 2 cycles later with unspecified data.

Reset
REQ-029 rst_in SHALL force wr_sel=0, clear the valid pipeline, and zero line_buffer_out, hcount_out, vcount_out and data_valid_out on the next edge.
REQ-030 RAM contents SHALL NOT be cleared.
REQ-031 Reset mid-line SHALL drop in-flight pixels; data_valid_out SHALL stay 0 for 2 cycles after rst_in deasserts.

Structure
REQ-032 Package line_buffer_pkg SHALL hold HRES/VRES defaults, the pixel_t (16-bit RGB565) typedef and the LB_LATENCY=2 constant.
REQ-033 Sub-module line_ram SHALL be a simple dual-port BRAM (width 16, depth HRES, 2-cycle read), instantiated 3 times.

Verification
REQ-034 Check: fill lines 0..2 with pixel = {line[4:0], column[10:0]}, then drive line 3 column 5 -> 2 cycles later, out = {line1, line2, line3} values at column 5, vcount_out=2, hcount_out=5.
REQ-035 Check: continuous frame, HRES=1280 -> wr_sel sequence 0,1,2,0 at each column-1279 boundary; no pixel mismatch across a 4-line window.
REQ-036 Check: insert 37 idle cycles mid-line -> wr_sel unchanged; outputs resume with exact 2-cycle alignment.
REQ-037 Check: vcount_in=0, hcount_in=0 valid -> vcount_out=719 two cycles later.
REQ-038 Check: assert rst_in at column 600 of line 10 -> next cycle all outputs 0, wr_sel=0; data_valid_out low until 2 cycles after the first post-reset valid.
REQ-039 Check: valid pixel at hcount_in=1300 -> no RAM write (verified by readback on the next line), wr_sel unchanged.
